systolic_feeder: RTL

Operand staging and skew stage directly upstream of the systolic MAC array. It buffers one N×N A matrix and one N×N B matrix, loaded a row at a time. On `start` it streams diagonally skewed operands: lane i of `a_column` carries row i of A delayed by i cycles, and lane j of `b_row` carries column j of B delayed by j cycles. These outputs drive the array's `new_a_column` / `new_b_row` inputs directly, followed by a zero drain long enough to flush the array.

---
 rtl/systolic_feeder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Operand staging and diagonal skew for an N x N systolic MAC array.
// Buffers one A and one B matrix row by row, then streams skewed lanes followed by a zero drain.
module systolic_feeder #(
  parameter int unsigned N        = 16,
  parameter int unsigned OP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [N*OP_WIDTH-1:0] load_a_row,
  input  logic [N*OP_WIDTH-1:0] load_b_row,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  feed_valid,
  output logic [N*OP_WIDTH-1:0] a_column,
  output logic [N*OP_WIDTH-1:0] b_row
);

  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  // Wide enough to hold 2N-2 without wrapping.
  localparam int unsigned PW = $clog2(2 * N);

  typedef enum logic [1:0] {StLoad, StReady, StFeed, StDrain} state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [PW-1:0]       t_q, t_d;
  logic [OP_WIDTH-1:0] a_mem [N][N];
  logic [OP_WIDTH-1:0] b_mem [N][N];
  logic                load_fire;
  logic [KW-1:0]       a_idx, b_idx;
  logic [N*OP_WIDTH-1:0] a_col_d, b_row_d;

  assign load_fire = load_valid && (state_q == StLoad) && !reset;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    case (state_q)
      StLoad: begin
        if (load_fire) begin
          k_d = k_q + 1'b1;
          if (k_q == KW'(N - 1)) begin
            state_d = StReady;
            k_d     = '0;
          end
        end
      end
      StReady: begin
        if (start) begin
          state_d = StFeed;
          t_d     = '0;
        end
      end
      StFeed: begin
        if (t_q == PW'(2 * N - 2)) begin
          state_d = StDrain;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StDrain: begin
        if (t_q == PW'(N - 1)) begin
          state_d = StLoad;
          t_d     = '0;
          k_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Lanes are computed from the next state so the registered outputs line up with state_q.
  always_comb begin
    a_col_d = '0;
    b_row_d = '0;
    a_idx   = '0;
    b_idx   = '0;
    if (state_d == StFeed) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(t_d) >= i) && (int'(t_d) - i < int'(N))) begin
          a_idx = KW'(int'(t_d) - i);
          b_idx = KW'(int'(t_d) - i);
          a_col_d[i*OP_WIDTH +: OP_WIDTH] = a_mem[KW'(i)][a_idx];
          b_row_d[i*OP_WIDTH +: OP_WIDTH] = b_mem[b_idx][KW'(i)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StLoad;
      k_q        <= '0;
      t_q        <= '0;
      a_column   <= '0;
      b_row      <= '0;
      feed_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      t_q        <= t_d;
      a_column   <= a_col_d;
      b_row      <= b_row_d;
      feed_valid <= (state_d == StFeed);
      busy       <= (state_d == StFeed) || (state_d == StDrain);
      done       <= (state_q == StDrain) && (state_d == StLoad);
      load_ready <= (state_d == StLoad);
    end
  end

  // Matrix storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      for (int m = 0; m < N; m++) begin
        a_mem[k_q][KW'(m)] <= load_a_row[m*OP_WIDTH +: OP_WIDTH];
        b_mem[k_q][KW'(m)] <= load_b_row[m*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

endmodule
